// File: rtl/mycpu_pkg.sv
// Shared pipeline definitions: bus widths, bus layouts and CSR bus field positions.
// Contents:
//   ES_TO_MS_BUS_WD / MS_TO_WS_BUS_WD / CSR_BUS_WD : inter-stage bus widths
//   CSR_*       : field positions inside the 92-bit CSR side bus
//   LD_*        : bit positions of the one-hot load_op field
//   es_to_ms_t  : EX->MEM bus layout
//   mem_req_of  : whether an EX->MEM instruction issued a data SRAM request
package mycpu_pkg;

  localparam int unsigned ES_TO_MS_BUS_WD = 80;
  localparam int unsigned MS_TO_WS_BUS_WD = 70;
  localparam int unsigned CSR_BUS_WD      = 92;

  // CSR side bus: {ex, ertn, csr_we, csr_num[8:0], payload[79:0]}
  localparam int unsigned CSR_EX_BIT   = 91;
  localparam int unsigned CSR_ERTN_BIT = 90;
  localparam int unsigned CSR_WE_BIT   = 89;
  localparam int unsigned CSR_NUM_MSB  = 88;
  localparam int unsigned CSR_NUM_LSB  = 80;

  // load_op = {ld_w, ld_b, ld_bu, ld_h, ld_hu}
  localparam int unsigned LD_W  = 4;
  localparam int unsigned LD_B  = 3;
  localparam int unsigned LD_BU = 2;
  localparam int unsigned LD_H  = 1;
  localparam int unsigned LD_HU = 0;

  typedef struct packed {
    logic        ale;
    logic        meaningful;
    logic [2:0]  mem_we;
    logic [4:0]  load_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } es_to_ms_t;

  // A misaligned or squashed access never reached the SRAM.
  function automatic logic mem_req_of(input es_to_ms_t b);
    return ((b.load_op != '0) | (b.mem_we != '0)) & b.meaningful & ~b.ale;
  endfunction

endpackage

// File: rtl/ld_extend.sv
// Load alignment and extension.
// Ports:
//   load_op : one-hot {ld_w, ld_b, ld_bu, ld_h, ld_hu}
//   offset  : address bits [1:0]
//   rdata   : raw 32-bit word from memory
//   value   : aligned, sign/zero-extended load value (rdata when not a load)
module ld_extend
  import mycpu_pkg::*;
(
  input  logic [4:0]  load_op,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] value
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    case (offset)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = offset[1] ? rdata[31:16] : rdata[15:0];

    value = rdata;
    case (1'b1)
      load_op[LD_W]:  value = rdata;
      load_op[LD_B]:  value = {{24{ld_byte[7]}}, ld_byte};
      load_op[LD_BU]: value = {24'b0, ld_byte};
      load_op[LD_H]:  value = {{16{ld_half[15]}}, ld_half};
      load_op[LD_HU]: value = {16'b0, ld_half};
      default:        value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data SRAM response of loads/stores, buffers a
// response that arrives while WB stalls, squashes responses of flushed accesses,
// and forms the load result.
// Ports:
//   clk, resetn                 : clock, asynchronous active-low reset
//   es_to_ms_valid/_bus/_csr_bus: instruction from EX
//   ms_allowin / ws_allowin     : handshake towards EX / from WB
//   data_sram_data_ok/_rdata    : data SRAM response
//   wb_flush                    : exception/ertn flush from WB
//   ms_to_ws_valid/_bus/_csr_bus: instruction to WB
//   ms_forward, ms_csr_forward  : bypass/hazard information for ID
//   ms_ex, ms_ertn_flush        : exception/ertn in flight in MEM
module mem_stage
  import mycpu_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [CSR_BUS_WD-1:0]      es_to_ms_csr_bus,
  output logic                       ms_allowin,
  input  logic                       ws_allowin,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       wb_flush,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [CSR_BUS_WD-1:0]      ms_to_ws_csr_bus,
  output logic [39:0]                ms_forward,
  output logic [11:0]                ms_csr_forward,
  output logic                       ms_ex,
  output logic                       ms_ertn_flush
);

  es_to_ms_t             es_bus;
  es_to_ms_t             ms_bus;
  logic [CSR_BUS_WD-1:0] ms_csr_bus;
  logic                  ms_valid;
  logic                  rbuf_valid;
  logic [31:0]           rbuf;
  logic [1:0]            discard_cnt;
  logic [1:0]            discard_cnt_d;

  logic        mem_req;
  logic        data_ok_hit;
  logic        ms_ready_go;
  logic        accept;
  logic        leave;
  logic        discard_inc;
  logic        discard_dec;
  logic        is_load;
  logic        load_pending;
  logic [31:0] ld_rdata;
  logic [31:0] ld_value;
  logic [31:0] final_result;

  assign es_bus  = es_to_ms_t'(es_to_ms_bus);
  assign mem_req = mem_req_of(ms_bus);
  assign is_load = ms_bus.load_op != '0;

  // Responses owed to flushed accesses arrive first and must not be taken as ours.
  assign data_ok_hit    = data_sram_data_ok & (discard_cnt == 2'd0) & ms_valid;
  assign ms_ready_go    = ~mem_req | data_ok_hit | rbuf_valid;
  assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go & ~wb_flush;
  assign accept         = es_to_ms_valid & ms_allowin;
  assign leave          = ms_to_ws_valid & ws_allowin;

  // An access still in flight when killed leaves one orphan response behind.
  assign discard_inc = wb_flush & ((ms_valid & mem_req & ~ms_ready_go) |
                                   (accept & mem_req_of(es_bus)));
  assign discard_dec = data_sram_data_ok & (discard_cnt != 2'd0);

  always_comb begin
    discard_cnt_d = discard_cnt + 2'(discard_inc) - 2'(discard_dec);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid    <= 1'b0;
      rbuf_valid  <= 1'b0;
      discard_cnt <= 2'd0;
    end else begin
      if (wb_flush) begin
        ms_valid <= 1'b0;
      end else if (ms_allowin) begin
        ms_valid <= es_to_ms_valid;
      end
      if (wb_flush | leave) begin
        rbuf_valid <= 1'b0;
      end else if (data_ok_hit & ~ws_allowin) begin
        rbuf_valid <= 1'b1;
      end
      discard_cnt <= discard_cnt_d;
    end
  end

  // Data registers are only meaningful under ms_valid / rbuf_valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      ms_bus     <= es_bus;
      ms_csr_bus <= es_to_ms_csr_bus;
    end
    if (data_ok_hit & ~ws_allowin) begin
      rbuf <= data_sram_rdata;
    end
  end

  assign ld_rdata = rbuf_valid ? rbuf : data_sram_rdata;

  ld_extend u_ld_extend (
    .load_op (ms_bus.load_op),
    .offset  (ms_bus.result[1:0]),
    .rdata   (ld_rdata),
    .value   (ld_value)
  );

  assign final_result = is_load ? ld_value : ms_bus.result;
  assign load_pending = ms_valid & is_load & mem_req & ~ms_ready_go;

  assign ms_to_ws_bus     = {ms_bus.gr_we, ms_bus.dest, final_result, ms_bus.pc};
  assign ms_to_ws_csr_bus = ms_csr_bus;
  assign ms_forward       = {ms_valid, load_pending, ms_bus.gr_we, ms_bus.dest, final_result};
  assign ms_ex            = ms_valid & ms_csr_bus[CSR_EX_BIT];
  assign ms_ertn_flush    = ms_valid & ms_csr_bus[CSR_ERTN_BIT];
  assign ms_csr_forward   = {1'b0, ms_ex, ms_valid & ms_csr_bus[CSR_WE_BIT],
                             ms_csr_bus[CSR_NUM_MSB:CSR_NUM_LSB]};

endmodule
